// File: rtl/bch_dec_syndrome_511_484_4bits.sv
// BCH(511,484) receive-side remainder unit: 4 bits per beat, r(x) mod g(x) plus message capture.
// Optional BCH_DEC_ERRCNT_EN adds saturating frame/error transfer counters.
module bch_dec_syndrome_511_484_4bits #(
    parameter int n = 511,
    parameter int k = 484,
    parameter int p = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [p-1:0]   din,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [k-1:0]   msg_out,
    output logic [n-k-1:0] rem_out,
    output logic           err
`ifdef BCH_DEC_ERRCNT_EN
    ,
    output logic [15:0]    frame_cnt,
    output logic [15:0]    err_cnt
`endif
);

    localparam int R          = n - k;
    localparam int BEATS      = (n + p - 1) / p;
    localparam int LAST_BITS  = n - p * (BEATS - 1);
    localparam logic [6:0]   CNT_LAST = 7'(BEATS - 1);
    localparam logic [6:0]   CNT_MSG  = 7'(k / p);
    localparam logic [R:0]   GEN      = 28'hD612B79;

    typedef enum logic [0:0] {
        S_RECV = 1'b0,
        S_OUT  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [6:0]     cnt_q, cnt_d;
    logic [R-1:0]   rem_q, rem_d;
    logic [k-1:0]   msg_q, msg_d;
    logic [R-1:0]   rem_out_q, rem_out_d;
    logic           err_q, err_d;
    logic [R-1:0]   rem_step_s;
    logic           last_beat_s;

    // One bit of long division: shift in the next coefficient, reduce by g(x) on overflow.
    function automatic logic [R-1:0] div_step(input logic [R-1:0] r, input logic b);
        return {r[R-2:0], b} ^ (r[R-1] ? GEN[R-1:0] : {R{1'b0}});
    endfunction

    assign last_beat_s = (cnt_q == CNT_LAST);

    // Unrolled division over one beat; the final beat only carries LAST_BITS leading bits.
    always_comb begin
        rem_step_s = rem_q;
        for (int i = p - 1; i >= 0; i--) begin
            if (!last_beat_s || (i >= p - LAST_BITS)) begin
                rem_step_s = div_step(rem_step_s, din[i]);
            end else begin
                rem_step_s = rem_step_s;
            end
        end
    end

    // Next-state logic for the receive/output handshake machine.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        msg_d     = msg_q;
        rem_out_d = rem_out_q;
        err_d     = err_q;
        case (state_q)
            S_RECV: begin
                if (in_valid) begin
                    rem_d = rem_step_s;
                    if (cnt_q < CNT_MSG) begin
                        msg_d = {msg_q[k-p-1:0], din};
                    end else begin
                        msg_d = msg_q;
                    end
                    // Counter parks on the last index until the result is taken.
                    if (last_beat_s) begin
                        state_d   = S_OUT;
                        rem_out_d = rem_step_s;
                        err_d     = |rem_step_s;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_RECV;
                    cnt_d   = 7'd0;
                    rem_d   = {R{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_RECV;
                cnt_d   = 7'd0;
                rem_d   = {R{1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_RECV;
            cnt_q     <= 7'd0;
            rem_q     <= {R{1'b0}};
            msg_q     <= {k{1'b0}};
            rem_out_q <= {R{1'b0}};
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            msg_q     <= msg_d;
            rem_out_q <= rem_out_d;
            err_q     <= err_d;
        end
    end

    // in_ready is forced low while reset is held so no beat is offered during reset.
    assign in_ready  = (state_q == S_RECV) && rst;
    assign out_valid = (state_q == S_OUT);
    assign msg_out   = msg_q;
    assign rem_out   = rem_out_q;
    assign err       = err_q;

`ifdef BCH_DEC_ERRCNT_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] err_cnt_q;
    logic        xfer_s;

    assign xfer_s = (state_q == S_OUT) && out_ready;

    // Saturating counters of completed result transfers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            if (xfer_s && (frame_cnt_q != 16'hFFFF)) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
                frame_cnt_q <= frame_cnt_q;
            end
            if (xfer_s && err_q && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end else begin
                err_cnt_q <= err_cnt_q;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule
